seq_monitor: RTL



---
 rtl/seq_monitor.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seq_monitor.sv
// Receive-side checker for the five-state two-lane staged sequence: decodes each
// qualified sample, tracks code order and per-state dwell, and flags frames and errors.
module seq_monitor #(
    parameter int unsigned D0    = 1,
    parameter int unsigned D1    = 2,
    parameter int unsigned D2    = 2,
    parameter int unsigned D3    = 2,
    parameter int unsigned D4    = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       din0,
    input  logic [1:0]       din1,
    output logic [2:0]       sym_idx,
    output logic             sym_vld,
    output logic             lock,
    output logic             frame_done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int unsigned D01   = (D0 > D1) ? D0 : D1;
    localparam int unsigned D23   = (D2 > D3) ? D2 : D3;
    localparam int unsigned D0123 = (D01 > D23) ? D01 : D23;
    localparam int unsigned D_MAX = (D0123 > D4) ? D0123 : D4;
    localparam int unsigned RUN_W = $clog2(D_MAX) + 1;

    typedef enum logic {HUNT, TRACK} state_t;

    function automatic logic [2:0] decode(input logic [1:0] a, input logic [1:0] b);
        case ({a, b})
            4'b0000: decode = 3'd0;
            4'b0101: decode = 3'd1;
            4'b0110: decode = 3'd2;
            4'b1010: decode = 3'd3;
            4'b1111: decode = 3'd4;
            default: decode = 3'd7;
        endcase
    endfunction

    function automatic logic [RUN_W-1:0] dwell(input logic [2:0] idx);
        case (idx)
            3'd0:    dwell = RUN_W'(D0);
            3'd1:    dwell = RUN_W'(D1);
            3'd2:    dwell = RUN_W'(D2);
            3'd3:    dwell = RUN_W'(D3);
            3'd4:    dwell = RUN_W'(D4);
            default: dwell = '0;
        endcase
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         exp_q, exp_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [2:0]         code, nxt_idx;
    logic [2:0]         sym_idx_d;
    logic               sym_vld_d, frame_d, err_d;
    logic [CNT_W-1:0]   err_cnt_d, frame_cnt_d;

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        run_d       = run_q;
        sym_idx_d   = sym_idx;
        sym_vld_d   = 1'b0;
        frame_d     = 1'b0;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt;
        frame_cnt_d = frame_cnt;
        code        = decode(din0, din1);
        nxt_idx     = (exp_q == 3'd4) ? 3'd0 : exp_q + 3'd1;

        if (en) begin
            sym_vld_d = 1'b1;
            sym_idx_d = code;
            case (state_q)
                HUNT: begin
                    if (code == 3'd0) begin
                        state_d = TRACK;
                        exp_d   = 3'd0;
                        run_d   = RUN_W'(1);
                    end
                end
                TRACK: begin
                    if (code == exp_q && run_q < dwell(exp_q)) begin
                        run_d = run_q + RUN_W'(1);
                    end else if (run_q == dwell(exp_q) && code == nxt_idx) begin
                        exp_d = nxt_idx;
                        run_d = RUN_W'(1);
                        if (exp_q == 3'd4) begin
                            frame_d     = 1'b1;
                            frame_cnt_d = frame_cnt + CNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                        if (err_cnt != '1)
                            err_cnt_d = err_cnt + CNT_W'(1);
                        // A code-0 sample that breaks the sequence also starts a new frame
                        if (code == 3'd0) begin
                            state_d = TRACK;
                            exp_d   = 3'd0;
                            run_d   = RUN_W'(1);
                        end else begin
                            state_d = HUNT;
                            exp_d   = 3'd0;
                            run_d   = '0;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            exp_q      <= '0;
            run_q      <= '0;
            sym_idx    <= '0;
            sym_vld    <= 1'b0;
            lock       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
            err_cnt    <= '0;
            frame_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            exp_q      <= exp_d;
            run_q      <= run_d;
            sym_idx    <= sym_idx_d;
            sym_vld    <= sym_vld_d;
            lock       <= (state_d == TRACK);
            frame_done <= frame_d;
            err        <= err_d;
            err_cnt    <= err_cnt_d;
            frame_cnt  <= frame_cnt_d;
        end
    end

endmodule
